// File: rtl/fifo_wr_arb.sv
// Purpose: packet-aware round-robin arbiter feeding one async-FIFO write port from REQ_NUM requesters.
// Latency: accepted beat reaches fifo_wen_o/fifo_wdata_o one clock later; one idle bubble per packet.
// Backpressure: fifo_afull_i drops the granted requester's ready; the grant is held until eop.
//
// Ports:
//   clk_i, rst_n_i            write clock, synchronous active-low reset
//   arb_en_i                  permits new grants (looked at only between packets)
//   req_valid_i/req_eop_i     per-requester beat valid and last-beat flag
//   req_data_i                per-requester payload, requester i at [i*WIDTH +: WIDTH]
//   req_ready_o               per-requester ready; a beat moves on valid & ready
//   fifo_wen_o/fifo_wdata_o   registered FIFO write, word = {src_id, eop, data}
//   fifo_afull_i/fifo_full_i  FIFO almost-full (stall) and full (error detect only)
//   busy_o, gnt_id_o, err_o   packet in progress, current/last grant, sticky write-while-full
module fifo_wr_arb #(
    parameter  int REQ_NUM = 4,
    parameter  int WIDTH   = 64,
    localparam int IDW     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int FW      = WIDTH + 1 + IDW
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     arb_en_i,
    input  logic [REQ_NUM-1:0]       req_valid_i,
    input  logic [REQ_NUM-1:0]       req_eop_i,
    input  logic [REQ_NUM*WIDTH-1:0] req_data_i,
    output logic [REQ_NUM-1:0]       req_ready_o,
    output logic                     fifo_wen_o,
    output logic [FW-1:0]            fifo_wdata_o,
    input  logic                     fifo_afull_i,
    input  logic                     fifo_full_i,
    output logic                     busy_o,
    output logic [IDW-1:0]           gnt_id_o,
    output logic                     err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   gnt_id_q;
    logic             fifo_wen_q;
    logic [FW-1:0]    fifo_wdata_q;
    logic             err_q;

    // Round-robin search: rotate the valid vector so bit 0 is the requester
    // at rr_ptr_q, then pick the lowest set bit of the rotated vector.
    logic [2*REQ_NUM-1:0] dbl_vld;
    logic [REQ_NUM-1:0]   rot_vld;
    logic [IDW-1:0]       winner_d;
    logic                 any_vld;
    int                   win_sum;

    assign dbl_vld = {req_valid_i, req_valid_i};
    assign rot_vld = REQ_NUM'(dbl_vld >> rr_ptr_q);
    assign any_vld = |req_valid_i;

    always_comb begin
        win_sum  = 0;
        winner_d = rr_ptr_q;
        // Walk offsets from the far end so the nearest valid one is written last.
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (rot_vld[k]) begin
                win_sum = int'(rr_ptr_q) + k;
                if (win_sum >= REQ_NUM) begin
                    win_sum = win_sum - REQ_NUM;
                end
                winner_d = IDW'(win_sum);
            end
        end
    end

    // Only the granted requester may see ready, and only while the FIFO has room.
    logic             accept;
    logic             acc_eop;
    logic [WIDTH-1:0] acc_data;
    logic [IDW-1:0]   rr_next;

    always_comb begin
        req_ready_o = '0;
        if (state_q == PKT) begin
            req_ready_o[gnt_id_q] = ~fifo_afull_i;
        end
    end

    assign accept   = (state_q == PKT) & req_valid_i[gnt_id_q] & ~fifo_afull_i;
    assign acc_eop  = req_eop_i[gnt_id_q];
    assign acc_data = req_data_i[gnt_id_q*WIDTH +: WIDTH];
    assign rr_next  = (gnt_id_q == IDW'(REQ_NUM - 1)) ? '0 : gnt_id_q + IDW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_id_q     <= '0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            fifo_wen_q <= accept;
            if (accept) begin
                fifo_wdata_q <= {gnt_id_q, acc_eop, acc_data};
            end
            // The write still goes out; the flag only records that it happened.
            if (fifo_wen_q && fifo_full_i) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (arb_en_i && !fifo_afull_i && any_vld) begin
                        gnt_id_q <= winner_d;
                        state_q  <= PKT;
                    end
                end
                PKT: begin
                    // Pointer moves past the winner only once its packet is done.
                    if (accept && acc_eop) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_wen_o   = fifo_wen_q;
    assign fifo_wdata_o = fifo_wdata_q;
    assign busy_o       = (state_q == PKT);
    assign gnt_id_o     = gnt_id_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Purpose: self-checking bench for fifo_wr_arb with a packet-level reference model.
// Latency: model predicts registered outputs one clock after each accepted beat.
// Backpressure: random and directed fifo_afull stalls are applied and checked.
module tb_fifo_wr_arb;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int FW  = W + 1 + IDW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arb_en;
    logic [N-1:0]     vld;
    logic [N-1:0]     eop;
    logic [N*W-1:0]   data;
    logic [N-1:0]     rdy;
    logic             wen;
    logic [FW-1:0]    wdata;
    logic             afull;
    logic             full;
    logic             busy;
    logic [IDW-1:0]   gnt;
    logic             err;

    fifo_wr_arb #(.REQ_NUM(N), .WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .arb_en_i     (arb_en),
        .req_valid_i  (vld),
        .req_eop_i    (eop),
        .req_data_i   (data),
        .req_ready_o  (rdy),
        .fifo_wen_o   (wen),
        .fifo_wdata_o (wdata),
        .fifo_afull_i (afull),
        .fifo_full_i  (full),
        .busy_o       (busy),
        .gnt_id_o     (gnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: which requester owns the FIFO, who is next in line,
    // and what the FIFO saw on the last clock.
    bit            m_live = 1'b0;
    bit            m_busy;
    int            m_owner;
    int            m_next;
    bit            m_wen;
    logic [FW-1:0] m_word;
    bit            m_err;

    task automatic model_step();
        bit take;
        if (!rst_n) begin
            m_live = 1'b1; m_busy = 1'b0; m_owner = 0; m_next = 0;
            m_wen = 1'b0; m_word = '0; m_err = 1'b0;
            return;
        end
        if (!m_live) return;
        m_err = m_err | (m_wen & full);
        take  = m_busy && vld[m_owner] && !afull;
        m_wen = take;
        if (take) m_word = {IDW'(m_owner), eop[m_owner], data[m_owner*W +: W]};
        if (m_busy) begin
            if (take && eop[m_owner]) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % N;
            end
        end else if (arb_en && !afull && vld != 0) begin
            for (int k = 0; k < N; k++) begin
                if (vld[(m_next + k) % N]) begin
                    m_owner = (m_next + k) % N;
                    break;
                end
            end
            m_busy = 1'b1;
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (m_live) begin
            exp_rdy = '0;
            if (m_busy) exp_rdy[m_owner] = !afull;
            chk("ready", rdy, exp_rdy);
            chk("wen",   wen, m_wen);
            chk("wdata", wdata, m_word);
            chk("busy",  busy, m_busy);
            chk("gnt",   gnt, m_owner);
            chk("err",   err, m_err);
        end
    end

    logic [N-1:0] acc_seen;

    task automatic cyc();
        @(negedge clk);
        acc_seen = vld & rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        vld = '0; eop = '0; afull = 1'b0; full = 1'b0; arb_en = 1'b1;
        repeat (n) cyc();
        rst_n = 1'b1;
    endtask

    int            beat;
    int            nw;
    int            cnt;
    logic [FW-1:0] words [$];

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; vld = '0; eop = '0; data = '0;
        afull = 1'b0; full = 1'b0;

        // T1: reset with every requester valid.
        vld = 4'hF;
        repeat (3) cyc();
        chk("t1_wen",   wen, 0);
        chk("t1_wdata", wdata, 0);
        chk("t1_busy",  busy, 0);
        chk("t1_gnt",   gnt, 0);
        chk("t1_err",   err, 0);
        chk("t1_ready", rdy, 0);
        rst_n = 1'b1;

        // T2: four requesters of single-beat packets -> strict rotation, half duty.
        eop = 4'hF;
        for (int i = 0; i < N; i++) data[i*W +: W] = W'(8'h10 * i);
        words.delete(); cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (wen) begin cnt++; words.push_back(wdata); end
        end
        chk("t2_duty", cnt, 5);
        for (int i = 0; i < 5 && i < words.size(); i++)
            chk("t2_src", words[i][FW-1 -: IDW], i % N);

        // T3: 5-beat packet from req0 holds the grant against req1.
        do_reset(2);
        vld = 4'b0011; eop = 4'b0010; beat = 0;
        data[1*W +: W] = 8'hB1;
        data[0 +: W] = 8'd0;
        words.delete();
        for (int c = 0; c < 40 && words.size() < 6; c++) begin
            cyc();
            if (wen) words.push_back(wdata);
            if (acc_seen[0]) beat++;
            if (beat >= 5) vld[0] = 1'b0;
            data[0 +: W] = W'(beat);
            eop[0] = (beat == 4);
        end
        vld = '0;
        chk("t3_nwords", words.size(), 6);
        if (words.size() >= 6) begin
            chk("t3_w0", words[0], 11'h000);
            chk("t3_w1", words[1], 11'h001);
            chk("t3_w2", words[2], 11'h002);
            chk("t3_w3", words[3], 11'h003);
            chk("t3_w4", words[4], 11'h104);
            chk("t3_w5", words[5], 11'h3B1);
        end

        // T4: almost-full stall after the first of four beats.
        do_reset(2);
        vld = 4'b0100; beat = 0; nw = 0;
        data[2*W +: W] = 8'h20; eop[2] = 1'b0;
        for (int c = 0; c < 20 && beat < 1; c++) begin
            cyc();
            if (wen) nw++;
            if (acc_seen[2]) beat++;
            data[2*W +: W] = W'(32'h20 + beat); eop[2] = (beat == 3);
        end
        chk("t4_start", beat, 1);
        afull = 1'b1; cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (wen || rdy != 0 || acc_seen != 0) cnt++;
        end
        chk("t4_stall", cnt, 0);
        chk("t4_gnt",   gnt, 2);
        chk("t4_busy",  busy, 1);
        afull = 1'b0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            cyc();
            if (wen) nw++;
            if (acc_seen[2]) beat++;
            if (beat >= 4) vld[2] = 1'b0;
            data[2*W +: W] = W'(32'h20 + beat); eop[2] = (beat == 3);
        end
        cyc();
        if (wen) nw++;
        chk("t4_nwords", nw, 4);
        chk("t4_last",   wdata, 11'h523);

        // T5: arb_en dropped mid-packet; packet finishes, then no new grant.
        do_reset(2);
        vld = 4'b1000; beat = 0;
        data[3*W +: W] = 8'h30; eop[3] = 1'b0;
        for (int c = 0; c < 20 && beat < 1; c++) begin
            cyc();
            if (acc_seen[3]) beat++;
            data[3*W +: W] = W'(32'h30 + beat); eop[3] = (beat == 2);
        end
        arb_en = 1'b0;
        vld[0] = 1'b1; eop[0] = 1'b1; data[0 +: W] = 8'h0A;
        for (int c = 0; c < 20 && beat < 3; c++) begin
            cyc();
            if (acc_seen[3]) beat++;
            if (beat >= 3) vld[3] = 1'b0;
            data[3*W +: W] = W'(32'h30 + beat); eop[3] = (beat == 2);
        end
        chk("t5_done", beat, 3);
        chk("t5_idle", busy, 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (busy || wen) cnt++;
        end
        chk("t5_nogrant", cnt, 0);
        arb_en = 1'b1;
        cyc();
        chk("t5_regrant", busy, 1);
        chk("t5_gnt0",    gnt, 0);
        vld = '0;

        // T6: write while full sets a sticky error; reset mid-packet clears it.
        do_reset(2);
        full = 1'b1; vld = 4'b0010; eop = 4'b0010; data[1*W +: W] = 8'h61;
        for (int c = 0; c < 10 && !wen; c++) cyc();
        chk("t6_wrote", wen, 1);
        vld = '0;
        cyc();
        chk("t6_err", err, 1);
        full = 1'b0;
        repeat (5) cyc();
        chk("t6_sticky", err, 1);
        vld = 4'b0100; eop = 4'b0000;
        for (int c = 0; c < 10 && !wen; c++) cyc();
        chk("t6_midpkt", busy, 1);
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err",  err, 0);
        chk("t6_rst_wen",  wen, 0);
        rst_n = 1'b1;
        vld = 4'b1010;
        cyc();
        chk("t6_rr_busy", busy, 1);
        chk("t6_rr_gnt",  gnt, 1);

        // Random traffic checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            arb_en = ($urandom_range(0, 7) != 0);
            vld    = N'($urandom);
            for (int i = 0; i < N; i++) eop[i] = ($urandom_range(0, 2) == 0);
            data   = (N*W)'($urandom);
            afull  = ($urandom_range(0, 4) == 0);
            full   = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
